// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// One full-adder cell, made of two half-adder stages and a carry register,
// is reused over WIDTH cycles, LSB first. Operands come in on a valid/ready
// handshake. The result is held in DONE until the consumer takes it.
// Optional feature: define SERIAL_ADD_SUB_EN to honour the sub input.
// With it, b is inverted and the carry is preset to 1, giving a - b.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  // Operand B as it enters the shift register, and the initial carry.
  logic [WIDTH-1:0] b_load;
  logic             carry_init;

`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  // The shared full-adder cell: two half-adder stages on the current LSBs.
  logic ha1_p, ha1_g, ha2_s, ha2_t, carry_nxt;
  assign ha1_p     = a_q[0] ^ b_q[0];
  assign ha1_g     = a_q[0] & b_q[0];
  assign ha2_s     = ha1_p ^ carry_q;
  assign ha2_t     = ha1_p & carry_q;
  assign carry_nxt = ha1_g | ha2_t;

  // Next-state and datapath control for IDLE -> RUN -> DONE.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path leaves one unassigned and no latch appears.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_load;
          carry_d = carry_init;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d            = a_q >> 1;
        b_d            = b_q >> 1;
        sum_d          = sum_q >> 1;
        sum_d[WIDTH-1] = ha2_s;
        carry_d        = carry_nxt;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          cout_d  = carry_nxt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, result and carry registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Operand shift registers.
  // NOTE: these have no reset because every accept reloads them before they are read.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8).
// Inputs are driven on the falling edge, and outputs are sampled there too.
// The expected results come from plain unsigned arithmetic.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int vectors    = 0;
  int miscompares = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: {cout, sum} from unsigned arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic sv);
    logic [W:0] r;
    r = {1'b0, av} + {1'b0, bv};
`ifdef SERIAL_ADD_SUB_EN
    if (sv) r = {(av >= bv), W'(av - bv)};
`endif
    return r;
  endfunction

  // Runs one operation with out_ready=1 and checks the latency, busy length and result.
  // The task starts just after a falling edge with the DUT in IDLE.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        input logic [W-1:0] exp_sum, input logic exp_cout, input string name);
    int lat;
    int busy_cnt;
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    sub       = sv;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end
    vectors++;
    if (lat !== W) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, W);
    end
    vectors++;
    if (busy_cnt !== W + 1) begin
      miscompares++;
      $display("FAIL %s busy length: got %0d, expected %0d", name, busy_cnt, W + 1);
    end
    vectors++;
    if (sum !== exp_sum || cout !== exp_cout) begin
      miscompares++;
      $display("FAIL %s result: got sum=%h cout=%b, expected sum=%h cout=%b",
               name, sum, cout, exp_sum, exp_cout);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s return to idle: got out_valid=%b busy=%b in_ready=%b, expected 0 0 1",
               name, out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        sum !== '0 || cout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset state: got in_ready=%b out_valid=%b busy=%b sum=%h cout=%b, expected all 0",
               in_ready, out_valid, busy, sum, cout);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset release in_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    run_op(8'h3C, 8'h0A, 1'b0, 8'h46, 1'b0, "basic_3C_0A");
  endtask

  task automatic test_bounds();
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "bound_FF_01");
    run_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, "bound_FF_FF");
    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "bound_00_00");
  endtask

  task automatic test_random_add();
    logic [W-1:0] av, bv;
    logic [W:0]   e;
    for (int i = 0; i < 8; i++) begin
      av = W'($urandom);
      bv = W'($urandom);
      e  = model(av, bv, 1'b0);
      run_op(av, bv, 1'b0, e[W-1:0], e[W], "random_add");
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] e1, e2;
    int         t;
    e1        = model(8'h5A, 8'h33, 1'b0);
    e2        = model(8'h11, 8'h22, 1'b0);
    in_valid  = 1'b1;
    a         = 8'h5A;
    b         = 8'h33;
    sub       = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    t = 0;
    while (!out_valid && t < 40) begin
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e1[W-1:0] || cout !== e1[W]) begin
        miscompares++;
        $display("FAIL backpressure hold %0d: got out_valid=%b in_ready=%b sum=%h cout=%b, expected 1 0 %h %b",
                 i, out_valid, in_ready, sum, cout, e1[W-1:0], e1[W]);
      end
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
    end
    a         = 8'h11;
    b         = 8'h22;
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure release: got out_valid=%b in_ready=%b, expected 0 1",
               out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure second accept: got busy=%b, expected 1", busy);
    end
    t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (sum !== e2[W-1:0] || cout !== e2[W] || t >= 40) begin
      miscompares++;
      $display("FAIL backpressure second result: got sum=%h cout=%b, expected %h %b",
               sum, cout, e2[W-1:0], e2[W]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    in_valid  = 1'b1;
    a         = 8'hA5;
    b         = 8'h5A;
    sub       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset mid run: got out_valid=%b busy=%b in_ready=%b, expected 0 0 1",
               out_valid, busy, in_ready);
    end
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "after_reset_10_20");
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp_q[$];
    logic [W:0] e;
    int         accept_cyc[$];
    int         cyc;
    int         accepted;
    int         results;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    accepted  = 0;
    results   = 0;
    cyc       = 0;
    while (results < 3 && cyc < 200) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        results++;
        vectors++;
        if (sum !== e[W-1:0] || cout !== e[W]) begin
          miscompares++;
          $display("FAIL back_to_back result %0d: got sum=%h cout=%b, expected %h %b",
                   results, sum, cout, e[W-1:0], e[W]);
        end
      end
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'($urandom);
      if (in_ready && accepted < 3) begin
        exp_q.push_back(model(a, b, sub));
        accept_cyc.push_back(cyc);
        accepted++;
        if (accepted == 3) begin
          @(posedge clk);
          #1;
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (results !== 3) begin
      miscompares++;
      $display("FAIL back_to_back count: got %0d results, expected 3", results);
    end
    for (int i = 1; i < accept_cyc.size(); i++) begin
      vectors++;
      if (accept_cyc[i] - accept_cyc[i-1] !== W + 2) begin
        miscompares++;
        $display("FAIL back_to_back spacing %0d: got %0d cycles, expected %0d",
                 i, accept_cyc[i] - accept_cyc[i-1], W + 2);
      end
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] av, bv;
    logic         sv;
    logic [W:0]   e;
`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, "sub_05_07");
    run_op(8'h07, 8'h07, 1'b1, 8'h00, 1'b1, "sub_07_07");
`else
    run_op(8'h05, 8'h07, 1'b1, 8'h0C, 1'b0, "sub_ignored_05_07");
`endif
    for (int i = 0; i < 6; i++) begin
      av = W'($urandom);
      bv = W'($urandom);
      sv = 1'($urandom);
      e  = model(av, bv, sv);
      run_op(av, bv, sv, e[W-1:0], e[W], "random_sub");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounds();
    test_random_add();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    @(negedge clk);
    test_sub();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
